id_regfile_sb: RTL and testbench
================================

# id_regfile_sb

Parametrised ID-stage register file with an integrated per-register pending-write scoreboard. Serves NUM_RD combinational read ports with WB-to-ID write-through bypass, and tracks in-flight writers. It raises ID_Stall when a source operand is still being produced by an instruction further down the pipeline. It sits in the ID stage between the instruction register and the ID/EX pipeline latch, and its write port is driven by WB.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width; depth = 2**ADDR_W, register 0 hardwired to zero
- NUM_RD, 2, number of read ports (1..4)
- CNT_W, 2, width of per-register in-flight counter; max in-flight writers per register = 2**CNT_W-1
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ID_ReadReg  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- ID_ReadUse  in  NUM_RD  port i operand is actually consumed (gates stall)
- ID_ReadData  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- ID_IssueFlag  in  1  instruction in ID leaves ID this cycle if not stalled
- ID_IssueReg  in  ADDR_W  destination of issuing instruction (0 = no write)
- ID_Stall  out  1  hold ID/IF, insert bubble
- WB_RetireFlag  in  1  instruction that was issued with nonzero dest retires this cycle
- WB_RegWriteFlag  in  1  retiring instruction actually writes (0 = squashed)
- WB_WriteReg  in  ADDR_W  retiring destination
- WB_WriteRegData  in  DATA_W  write data
- ID_ScoreFull  out  1  issue blocked because ID_IssueReg counter saturated

## Operation
- Write: at rising clk, if WB_RegWriteFlag && WB_RetireFlag && WB_WriteReg!=0, regs[WB_WriteReg] <= WB_WriteRegData. Writes to 0 ignored.
- Read port i: if addr==0 -> 0; else if write condition true and WB_WriteReg==addr -> WB_WriteRegData (bypass); else regs[addr].
- Counter cnt[r], r=1..2**ADDR_W-1; cnt[0] constant 0.
  - inc = ID_IssueFlag && !ID_Stall && ID_IssueReg==r (r!=0)
  - dec = WB_RetireFlag && WB_WriteReg==r
  - inc&&dec: unchanged; inc only: +1; dec only: -1.
  - dec with cnt==0 is a protocol error; counter holds at 0 (no wrap).
- Hazard for port i: ID_ReadUse[i] && addr!=0 && eff_cnt(addr)!=0. eff_cnt = cnt minus 1 if dec on that reg this cycle. A single pending writer retiring now is covered by the bypass, so it causes no stall.
- ID_ScoreFull = ID_IssueFlag && ID_IssueReg!=0 && cnt[ID_IssueReg]==max && !dec on that reg.
- ID_Stall = OR of port hazards | ID_ScoreFull. Combinational; no dependence on ID_Stall itself beyond gating inc.
- A squashed retire (RetireFlag=1, RegWriteFlag=0) decrements without writing; the bypass is not applied.

## Timing
- Reads, bypass and ID_Stall are combinational, zero-cycle latency from address and WB inputs.
- Writes and counter updates take effect at the next rising edge and are visible to plain reads the cycle after.
- Reset (rst_n=0, any time, asynchronous): all regs=0, all cnt=0. Outputs read 0, ID_Stall=0, ID_ScoreFull=0 while reset is held. Released on a synchronised deassertion supplied externally.
- Reset mid-operation discards all pending counts; the pipeline is flushed by the same reset.

## Structure
- Shared package rf_pkg: DATA_W/ADDR_W defaults, REG_ZERO constant, and the field offsets RS_LSB=21 and RT_LSB=16 used by ID to build ID_ReadReg.
- One sub-module: rf_scoreboard (counter array, inc/dec, eff_cnt, hazard and full logic). The storage array and bypass muxes stay in the top.

## Test plan
- Reset, then read regs 0..31 -> all 0; ID_Stall=0.
- WB writes r5=0xDEADBEEF; the same cycle, port0 reads r5 -> 0xDEADBEEF (bypass). Next cycle, plain read -> 0xDEADBEEF. Write to r0=0x1234 -> r0 still reads 0.
- Issue dest r3; next cycle, port1 reads r3 with ReadUse=1 -> ID_Stall=1. With ReadUse=0 -> ID_Stall=0. When WB retires r3=7 -> same cycle ID_Stall=0 and data=7.
- Issue r4 three times (CNT_W=2) with no retire -> fourth issue gives ID_ScoreFull=1 and ID_Stall=1. Issue and retire r4 in the same cycle -> cnt stays 3 and no full.
- Issue r6 then squashed retire of r6 (RegWriteFlag=0) -> cnt back to 0, r6 unchanged, no stall.
- Assert rst_n low with cnt[3]=2 and r3=9 -> immediately r3 reads 0 and ID_Stall=0; after release, no stall on r3.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the ID-stage register file and its instruction decode.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Architectural zero register: reads as 0, writes discarded, never tracked.
  localparam int unsigned REG_ZERO = 0;

  // Source register fields in the instruction word, used by ID to build ID_ReadReg.
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight writer counters plus the read-hazard and saturation stall logic.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  input  logic                     issue_flag,
  input  logic [ADDR_W-1:0]        issue_reg,
  input  logic                     retire_flag,
  input  logic [ADDR_W-1:0]        retire_reg,
  output logic                     stall,
  output logic                     score_full
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [Depth];
  logic [CNT_W-1:0] cnt_d [Depth];
  logic [NUM_RD-1:0] hazard;

  logic [CNT_W-1:0] issue_cnt;
  logic             issue_dec;

  // A source is hazardous only if writers remain after discounting one retiring right now,
  // since that single retiring writer is served by the write-through bypass.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  eff_cnt;

    assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
    assign cnt     = cnt_q[addr];
    assign eff_cnt = (retire_flag && (retire_reg == addr) && (cnt != '0)) ? cnt - CntOne : cnt;
    assign hazard[i] = rd_use[i] && (addr != Zero) && (eff_cnt != '0);
  end

  // Issue is refused when the destination counter would overflow.
  assign issue_cnt  = cnt_q[issue_reg];
  assign issue_dec  = retire_flag && (retire_reg == issue_reg);
  assign score_full = issue_flag && (issue_reg != Zero) && (issue_cnt == CntMax) && !issue_dec;
  assign stall      = (|hazard) || score_full;

  // Next-state counters: simultaneous inc and dec cancel; dec at zero holds (protocol error).
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned r = 0; r < Depth; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int unsigned r = 1; r < Depth; r++) begin
      inc = issue_flag && !stall && (issue_reg == ADDR_W'(r));
      dec = retire_flag && (retire_reg == ADDR_W'(r));
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
    cnt_d[0] = '0;
  end

  // Counter state; reset discards every pending count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < Depth; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < Depth; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage register file with WB write-through bypass and an in-flight writer scoreboard.
module id_regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ID_ReadReg,
  input  logic [NUM_RD-1:0]        ID_ReadUse,
  output logic [NUM_RD*DATA_W-1:0] ID_ReadData,
  input  logic                     ID_IssueFlag,
  input  logic [ADDR_W-1:0]        ID_IssueReg,
  output logic                     ID_Stall,
  input  logic                     WB_RetireFlag,
  input  logic                     WB_RegWriteFlag,
  input  logic [ADDR_W-1:0]        WB_WriteReg,
  input  logic [DATA_W-1:0]        WB_WriteRegData,
  output logic                     ID_ScoreFull
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [Depth];
  logic              wen;

  // Squashed retires still release the scoreboard but must not write or bypass.
  assign wen = WB_RegWriteFlag && WB_RetireFlag && (WB_WriteReg != Zero);

  // Register storage; register 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < Depth; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wen) begin
      regs_q[WB_WriteReg] <= WB_WriteRegData;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = ID_ReadReg[i*ADDR_W +: ADDR_W];

    // Read mux: zero register, then same-cycle WB bypass, then storage. Forced 0 in reset.
    always_comb begin
      rd_data = regs_q[rd_addr];
      if (!rst_n || (rd_addr == Zero)) begin
        rd_data = '0;
      end else if (wen && (WB_WriteReg == rd_addr)) begin
        rd_data = WB_WriteRegData;
      end
    end

    assign ID_ReadData[i*DATA_W +: DATA_W] = rd_data;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (ID_ReadReg),
    .rd_use      (ID_ReadUse),
    .issue_flag  (ID_IssueFlag),
    .issue_reg   (ID_IssueReg),
    .retire_flag (WB_RetireFlag),
    .retire_reg  (WB_WriteReg),
    .stall       (ID_Stall),
    .score_full  (ID_ScoreFull)
  );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: behavioural model with per-cycle compare plus directed literal checks.
module tb_id_regfile_sb;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int Depth = 32;
  localparam int CntMax = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR*AW-1:0] ID_ReadReg;
  logic [NR-1:0]    ID_ReadUse;
  logic [NR*DW-1:0] ID_ReadData;
  logic           ID_IssueFlag;
  logic [AW-1:0]  ID_IssueReg;
  logic           ID_Stall;
  logic           WB_RetireFlag;
  logic           WB_RegWriteFlag;
  logic [AW-1:0]  WB_WriteReg;
  logic [DW-1:0]  WB_WriteRegData;
  logic           ID_ScoreFull;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] m_regs [Depth] = '{default: '0};
  int            m_cnt  [Depth] = '{default: 0};

  always #5 clk = ~clk;

  id_regfile_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .CNT_W  (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_ReadReg      (ID_ReadReg),
    .ID_ReadUse      (ID_ReadUse),
    .ID_ReadData     (ID_ReadData),
    .ID_IssueFlag    (ID_IssueFlag),
    .ID_IssueReg     (ID_IssueReg),
    .ID_Stall        (ID_Stall),
    .WB_RetireFlag   (WB_RetireFlag),
    .WB_RegWriteFlag (WB_RegWriteFlag),
    .WB_WriteReg     (WB_WriteReg),
    .WB_WriteRegData (WB_WriteRegData),
    .ID_ScoreFull    (ID_ScoreFull)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_eff(input logic [AW-1:0] a);
    int c;
    c = m_cnt[a];
    if (WB_RetireFlag && WB_WriteReg == a && c > 0) c = c - 1;
    return c;
  endfunction

  function automatic logic m_full();
    return ID_IssueFlag && ID_IssueReg != 0 && m_cnt[ID_IssueReg] == CntMax &&
           !(WB_RetireFlag && WB_WriteReg == ID_IssueReg);
  endfunction

  function automatic logic m_stall();
    logic s;
    logic [AW-1:0] a;
    s = m_full();
    for (int i = 0; i < NR; i++) begin
      a = ID_ReadReg[i*AW +: AW];
      if (ID_ReadUse[i] && a != 0 && m_eff(a) != 0) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] m_rd(input int i);
    logic [AW-1:0] a;
    a = ID_ReadReg[i*AW +: AW];
    if (!rst_n || a == 0) return '0;
    if (WB_RetireFlag && WB_RegWriteFlag && WB_WriteReg == a) return WB_WriteRegData;
    return m_regs[a];
  endfunction

  // Model state update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < Depth; r++) begin
        m_regs[r] <= '0;
        m_cnt[r]  <= 0;
      end
    end else begin
      for (int r = 1; r < Depth; r++) begin
        if ((ID_IssueFlag && !m_stall() && ID_IssueReg == r) &&
            !(WB_RetireFlag && WB_WriteReg == r))
          m_cnt[r] <= m_cnt[r] + 1;
        else if (!(ID_IssueFlag && !m_stall() && ID_IssueReg == r) &&
                 (WB_RetireFlag && WB_WriteReg == r) && m_cnt[r] > 0)
          m_cnt[r] <= m_cnt[r] - 1;
      end
      if (WB_RetireFlag && WB_RegWriteFlag && WB_WriteReg != 0)
        m_regs[WB_WriteReg] <= WB_WriteRegData;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++)
      chk($sformatf("cmp_rd%0d", i), ID_ReadData[i*DW +: DW], m_rd(i));
    chk("cmp_stall", DW'(ID_Stall), DW'(m_stall()));
    chk("cmp_full", DW'(ID_ScoreFull), DW'(m_full()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_IssueFlag    = 1'b0;
    ID_IssueReg     = '0;
    WB_RetireFlag   = 1'b0;
    WB_RegWriteFlag = 1'b0;
    WB_WriteReg     = '0;
    WB_WriteRegData = '0;
  endtask

  // Port 0 takes rs, port 1 takes rt, extracted from an instruction word as ID does.
  task automatic set_rd(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [1:0] use_v);
    logic [31:0] instr;
    instr = '0;
    instr[RS_LSB +: AW] = rs;
    instr[RT_LSB +: AW] = rt;
    ID_ReadReg = {instr[RT_LSB +: AW], instr[RS_LSB +: AW]};
    ID_ReadUse = use_v;
  endtask

  task automatic wb(input logic [AW-1:0] r, input logic [DW-1:0] d, input logic wr);
    WB_RetireFlag   = 1'b1;
    WB_RegWriteFlag = wr;
    WB_WriteReg     = r;
    WB_WriteRegData = d;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    ID_IssueFlag = 1'b1;
    ID_IssueReg  = r;
  endtask

  function automatic logic [DW-1:0] rd0();
    return ID_ReadData[0 +: DW];
  endfunction

  function automatic logic [DW-1:0] rd1();
    return ID_ReadData[DW +: DW];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd0, 2'b00);
    #1;
    chk("rst_stall", DW'(ID_Stall), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // All registers read zero after reset
    for (int k = 0; k < Depth; k++) begin
      set_rd(AW'(k), AW'(Depth - 1 - k), 2'b11);
      #1;
      chk("reset_rd0", rd0(), 32'h0);
      chk("reset_rd1", rd1(), 32'h0);
      chk("reset_stall", DW'(ID_Stall), 0);
    end
    cyc();

    // Write-through bypass, then plain read, then r0 write ignored
    set_rd(5'd5, 5'd0, 2'b00);
    wb(5'd5, 32'hDEADBEEF, 1'b1);
    #1;
    chk("bypass_r5", rd0(), 32'hDEADBEEF);
    cyc();
    idle();
    #1;
    chk("plain_r5", rd0(), 32'hDEADBEEF);
    set_rd(5'd0, 5'd5, 2'b00);
    wb(5'd0, 32'h1234, 1'b1);
    #1;
    chk("r0_bypass_zero", rd0(), 32'h0);
    cyc();
    idle();
    #1;
    chk("r0_zero", rd0(), 32'h0);
    chk("r5_port1", rd1(), 32'hDEADBEEF);

    // RAW hazard on r3, gated by ReadUse, cleared by same-cycle retire
    issue(5'd3);
    cyc();
    idle();
    set_rd(5'd0, 5'd3, 2'b10);
    #1;
    chk("raw_stall", DW'(ID_Stall), 1);
    ID_ReadUse = 2'b00;
    #1;
    chk("raw_unused", DW'(ID_Stall), 0);
    ID_ReadUse = 2'b10;
    wb(5'd3, 32'd7, 1'b1);
    #1;
    chk("retire_nostall", DW'(ID_Stall), 0);
    chk("retire_bypass", rd1(), 32'd7);
    cyc();
    idle();
    #1;
    chk("after_retire_stall", DW'(ID_Stall), 0);
    chk("after_retire_r3", rd1(), 32'd7);

    // Saturate r4 counter
    set_rd(5'd0, 5'd0, 2'b00);
    issue(5'd4);
    repeat (3) cyc();
    chk("full_set", DW'(ID_ScoreFull), 1);
    chk("full_stall", DW'(ID_Stall), 1);
    wb(5'd4, 32'd44, 1'b1);
    #1;
    chk("full_cleared_by_dec", DW'(ID_ScoreFull), 0);
    chk("full_cleared_stall", DW'(ID_Stall), 0);
    cyc();
    WB_RetireFlag = 1'b0;
    #1;
    chk("cnt_held_full", DW'(ID_ScoreFull), 1);
    idle();
    wb(5'd4, 32'd44, 1'b1);
    repeat (3) cyc();
    idle();
    set_rd(5'd4, 5'd0, 2'b01);
    #1;
    chk("drained_stall", DW'(ID_Stall), 0);
    chk("drained_r4", rd0(), 32'd44);
    cyc();

    // Squashed retire releases the counter without writing
    set_rd(5'd0, 5'd0, 2'b00);
    issue(5'd6);
    cyc();
    idle();
    set_rd(5'd6, 5'd0, 2'b01);
    #1;
    chk("r6_pending", DW'(ID_Stall), 1);
    wb(5'd6, 32'hBAD0BAD0, 1'b0);
    #1;
    chk("squash_nostall", DW'(ID_Stall), 0);
    chk("squash_nobypass", rd0(), 32'h0);
    cyc();
    idle();
    #1;
    chk("squash_cnt0", DW'(ID_Stall), 0);
    chk("squash_r6", rd0(), 32'h0);

    // Asynchronous reset mid-operation
    set_rd(5'd0, 5'd0, 2'b00);
    wb(5'd3, 32'd9, 1'b1);
    cyc();
    idle();
    issue(5'd3);
    repeat (2) cyc();
    idle();
    set_rd(5'd0, 5'd3, 2'b10);
    #1;
    chk("pre_rst_stall", DW'(ID_Stall), 1);
    chk("pre_rst_r3", rd1(), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("in_rst_r3", rd1(), 32'h0);
    chk("in_rst_stall", DW'(ID_Stall), 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", DW'(ID_Stall), 0);
    chk("post_rst_r3", rd1(), 32'h0);
    cyc();
    chk("post_rst_stall2", DW'(ID_Stall), 0);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
